pipeline_wb_unit: RTL and testbench
===================================

Name: pipeline_wb_unit

Overview:
- Registered, parametrised RV32I write-back stage.
- Accepts retiring instructions from MEM through a valid/ready handshake and waits for late data-memory responses with a bounded timeout.
- Aligns and sign- or zero-extends sub-word loads, and drives one register-file write port.
- Adds flush, x0 write suppression and a retired-instruction counter, none of which the combinational write-back path provides.

Parameters:
XLEN, 32, datapath width; loads extend to XLEN (only 32 is required to be supported).
REG_ADDR_W, 5, register index width.
LOAD_TIMEOUT, 16, maximum number of cycles spent in LOAD_WAIT before abort; must be ≥2.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_n_i  input  1  asynchronous, active-low reset.
valid_i  input  1  MEM presents an instruction this cycle.
ready_o  output  1  stage can accept an instruction this cycle.
opcode_i  input  6  pipeline opcode class.
funct3_i  input  3  load size and sign.
addr_lo_i  input  2  load byte offset, taken from alu_out[1:0].
rd_i  input  REG_ADDR_W  destination register.
alu_out_i  input  XLEN  ALU, jump, AUIPC or LUI result.
dmem_valid_i  input  1  dmem_data_i is valid this cycle.
dmem_data_i  input  32  raw data-memory read word.
flush_i  input  1  kill the pending load and block acceptance this cycle.
reg_we_o  output  1  register-file write enable.
rd_o  output  REG_ADDR_W  register-file write index.
reg_data_o  output  XLEN  register-file write data.
load_err_o  output  1  one-cycle pulse when a load times out.
retire_cnt_o  output  CNT_W  number of instructions completed.

Behaviour:
- Decode:
  - opcode_i[5]=0: ALU class; write alu_out_i.
  - opcode_i[5]=1, opcode_i[4:3]=01 or 10: store or branch; no write.
  - opcode_i[4:3]=11: jump, AUIPC or LUI; write alu_out_i.
  - opcode_i[4:3]=00: load.
- Accept condition: accept = valid_i & ready_o & ~flush_i.
- ready_o is combinational: ready_o = (state==IDLE).
- States:
  - IDLE:
    - Accepted non-load: output register loads {we, rd, data} and the write appears the next cycle. Latency is 1 and throughput is 1 per cycle.
    - Accepted load with dmem_valid_i=1 in the same cycle: data is aligned and registered, and the write appears the next cycle.
    - Accepted load with dmem_valid_i=0: capture funct3, addr_lo and rd; go to LOAD_WAIT; clear the timeout counter.
  - LOAD_WAIT:
    - ready_o=0.
    - The counter increments every cycle.
    - dmem_valid_i=1: register the aligned write; return to IDLE; reg_we_o=1 on the next cycle.
    - flush_i=1: return to IDLE with no write and no retire count. flush_i has priority over dmem_valid_i in the same cycle.
    - counter == LOAD_TIMEOUT-1 without data: pulse load_err_o for one cycle; no write; return to IDLE; no retire count.
- Output register:
  - reg_we_o is a one-cycle pulse per completed write.
  - If nothing completes in a cycle, reg_we_o=0 on the next cycle and rd_o/reg_data_o hold their last value.
- rd=0: reg_we_o is forced to 0. The instruction still counts as retired.
- Load alignment (byte lane = addr_lo; half-word selected by addr_lo[1]):
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the half-word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the half-word.
  - 010 and all other codes: full word.
  - Misaligned LH/LW are not checked.
- retire_cnt_o:
  - Increments by 1 on the cycle each instruction completes: non-load accept, or load data registered. This includes stores, branches and rd=0 writes.
  - Wraps modulo 2^CNT_W.
- flush_i does not cancel a write already in the output register.
- Reset, asynchronous and mid-operation:
  - state=IDLE, counters=0.
  - reg_we_o=0, rd_o=0, reg_data_o=0, load_err_o=0, retire_cnt_o=0.
  - ready_o=1 after deassertion.
  - Any pending load is dropped.

Test Plan:
- ALU back-to-back: opcode 000000, rd=3, alu 0x11, then rd=4, alu 0x22 on consecutive cycles -> reg_we_o=1 on two consecutive cycles with (3,0x11) then (4,0x22); retire_cnt_o=2.
- Store then write to x0: opcode 101000, then ALU with rd=0 -> reg_we_o stays 0 throughout; retire_cnt_o=2.
- Delayed LB: funct3=000, addr_lo=2, rd=5, dmem_valid_i rises 3 cycles later with data 0x12F45678 -> ready_o=0 for 3 cycles; then (5, 0xFFFFFFF4).
- Same-cycle LHU: dmem_valid_i=1 on accept, addr_lo=2, data 0x8001ABCD -> next cycle (rd, 0x00008001).
- Timeout: load accepted and dmem_valid_i never rises, LOAD_TIMEOUT=16 -> load_err_o pulses once, 16 cycles after accept; no write; ready_o=1 again.
- Flush versus data: in LOAD_WAIT, flush_i=1 and dmem_valid_i=1 in the same cycle -> no write, retire count unchanged. Separately, rst_n_i low mid-LOAD_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_wb_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_wb_unit_if
// Desc     : MEM handshake, data-memory response and register-file write bundle
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_wb_unit_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic [5:0]            opcode_i;
  logic [2:0]            funct3_i;
  logic [1:0]            addr_lo_i;
  logic [REG_ADDR_W-1:0] rd_i;
  logic [XLEN-1:0]       alu_out_i;
  logic                  dmem_valid_i;
  logic [31:0]           dmem_data_i;
  logic                  flush_i;
  logic                  reg_we_o;
  logic [REG_ADDR_W-1:0] rd_o;
  logic [XLEN-1:0]       reg_data_o;
  logic                  load_err_o;
  logic [CNT_W-1:0]      retire_cnt_o;

  // Write-back stage side.
  modport slave (
    input  valid_i, opcode_i, funct3_i, addr_lo_i, rd_i, alu_out_i,
           dmem_valid_i, dmem_data_i, flush_i,
    output ready_o, reg_we_o, rd_o, reg_data_o, load_err_o, retire_cnt_o
  );

  // MEM stage / memory / register-file side.
  modport master (
    output valid_i, opcode_i, funct3_i, addr_lo_i, rd_i, alu_out_i,
           dmem_valid_i, dmem_data_i, flush_i,
    input  ready_o, reg_we_o, rd_o, reg_data_o, load_err_o, retire_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_wb_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_wb_unit
// Desc     : Registered RV32I write-back stage with late-load wait and timeout
// Revision : 1.0  initial release
// ============================================================================
module pipeline_wb_unit #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  wire logic         clk_i,
  input  wire logic         rst_n_i,
  pipeline_wb_unit_if.slave bus
);

  localparam int TO_W = $clog2(LOAD_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(LOAD_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [TO_W-1:0]       wait_q, wait_d;
  logic [2:0]            ld_f3_q, ld_f3_d;
  logic [1:0]            ld_off_q, ld_off_d;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  w_is_load;
  logic                  w_writes;
  logic                  w_accept;
  logic [XLEN-1:0]       w_load_now;
  logic [XLEN-1:0]       w_load_late;
  logic                  unused_opcode_bits;

  function automatic logic [XLEN-1:0] align_load(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  align_load = XLEN'($signed(b));
      3'b001:  align_load = XLEN'($signed(h));
      3'b100:  align_load = XLEN'(b);
      3'b101:  align_load = XLEN'(h);
      default: align_load = XLEN'(word);
    endcase
  endfunction

  // opcode[5]=0 is always ALU; otherwise bits [4:3] pick load/store/branch/jump.
  assign w_is_load          = bus.opcode_i[5] & (bus.opcode_i[4:3] == 2'b00);
  assign w_writes           = ~bus.opcode_i[5] | (bus.opcode_i[4:3] == 2'b11);
  assign w_accept           = bus.valid_i & (state_q == ST_IDLE) & ~bus.flush_i;
  assign w_load_now         = align_load(bus.funct3_i, bus.addr_lo_i, bus.dmem_data_i);
  assign w_load_late        = align_load(ld_f3_q, ld_off_q, bus.dmem_data_i);
  assign unused_opcode_bits = ^bus.opcode_i[2:0];

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    ld_rd_d  = ld_rd_q;
    we_d     = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_is_load) begin
            we_d   = w_writes & (bus.rd_i != '0);
            rd_d   = bus.rd_i;
            data_d = bus.alu_out_i;
            cnt_d  = cnt_q + CNT_ONE;
          end else if (bus.dmem_valid_i) begin
            we_d   = (bus.rd_i != '0);
            rd_d   = bus.rd_i;
            data_d = w_load_now;
            cnt_d  = cnt_q + CNT_ONE;
          end else begin
            state_d  = ST_LOAD_WAIT;
            wait_d   = '0;
            ld_f3_d  = bus.funct3_i;
            ld_off_d = bus.addr_lo_i;
            ld_rd_d  = bus.rd_i;
          end
        end
      end

      ST_LOAD_WAIT: begin
        wait_d = wait_q + TO_ONE;
        // Flush beats a same-cycle response; a response beats the timeout.
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else if (bus.dmem_valid_i) begin
          state_d = ST_IDLE;
          we_d    = (ld_rd_q != '0);
          rd_d    = ld_rd_q;
          data_d  = w_load_late;
          cnt_d   = cnt_q + CNT_ONE;
        end else if (wait_q == TO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
      ld_rd_q  <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
      ld_rd_q  <= ld_rd_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ready_o      = (state_q == ST_IDLE);
  assign bus.reg_we_o     = we_q;
  assign bus.rd_o         = rd_q;
  assign bus.reg_data_o   = data_q;
  assign bus.load_err_o   = err_q;
  assign bus.retire_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_wb_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_wb_unit
// Desc     : Directed and randomized bench for pipeline_wb_unit
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_wb_unit;
  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int LOAD_TIMEOUT = 16;
  localparam int CNT_W        = 32;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  pipeline_wb_unit_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

  pipeline_wb_unit #(
    .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: one outstanding load at most, plus the retire total.
  bit          m_busy;
  int          m_wait;
  int          m_f3, m_off, m_rd;
  int unsigned m_cnt;
  bit          exp_we, exp_err;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // 0 = writes alu_out, 1 = store/branch, 2 = load
  function automatic int op_class(input int op);
    int sub;
    if (op < 32) return 0;
    sub = (op / 8) % 4;
    if (sub == 0) return 2;
    if (sub == 3) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      0:       return (b >= 128) ? b - 256 : b;
      1:       return (h >= 32768) ? h - 65536 : h;
      4:       return b;
      5:       return h;
      default: return w;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [5:0] op, input logic [2:0] f3,
                       input logic [1:0] off, input logic [4:0] rd, input logic [31:0] alu,
                       input bit dv, input logic [31:0] dd, input bit fl);
    bus.valid_i      = v;
    bus.opcode_i     = op;
    bus.funct3_i     = f3;
    bus.addr_lo_i    = off;
    bus.rd_i         = rd;
    bus.alu_out_i    = alu;
    bus.dmem_valid_i = dv;
    bus.dmem_data_i  = dd;
    bus.flush_i      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 3'd0, 2'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // Predict this cycle's outcome, clock once, compare.
  task automatic step();
    int cls;
    check("ready", {63'd0, bus.ready_o}, {63'd0, !m_busy});
    exp_we  = 1'b0;
    exp_err = 1'b0;
    if (!m_busy) begin
      if (bus.valid_i && !bus.flush_i) begin
        cls = op_class(int'(bus.opcode_i));
        if (cls != 2) begin
          m_cnt++;
          if (cls == 0 && bus.rd_i != 0) begin
            exp_we = 1'b1; exp_rd = bus.rd_i; exp_data = bus.alu_out_i;
          end
        end else if (bus.dmem_valid_i) begin
          m_cnt++;
          if (bus.rd_i != 0) begin
            exp_we   = 1'b1;
            exp_rd   = bus.rd_i;
            exp_data = ref_load(int'(bus.funct3_i), int'(bus.addr_lo_i), bus.dmem_data_i);
          end
        end else begin
          m_busy = 1'b1;
          m_wait = 0;
          m_f3   = int'(bus.funct3_i);
          m_off  = int'(bus.addr_lo_i);
          m_rd   = int'(bus.rd_i);
        end
      end
    end else if (bus.flush_i) begin
      m_busy = 1'b0;
    end else if (bus.dmem_valid_i) begin
      m_busy = 1'b0;
      m_cnt++;
      if (m_rd != 0) begin
        exp_we   = 1'b1;
        exp_rd   = 5'(m_rd);
        exp_data = ref_load(m_f3, m_off, bus.dmem_data_i);
      end
    end else if (m_wait == LOAD_TIMEOUT - 1) begin
      m_busy  = 1'b0;
      exp_err = 1'b1;
    end else begin
      m_wait++;
    end
    @(posedge clk_i);
    #1;
    check("we", {63'd0, bus.reg_we_o}, {63'd0, exp_we});
    if (exp_we) begin
      check("rd", {59'd0, bus.rd_o}, {59'd0, exp_rd});
      check("data", {32'd0, bus.reg_data_o}, {32'd0, exp_data});
    end
    check("err", {63'd0, bus.load_err_o}, {63'd0, exp_err});
    check("cnt", {32'd0, bus.retire_cnt_o}, {32'd0, m_cnt});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"},    {63'd0, bus.reg_we_o}, 64'd0);
    check({tag, "_rd"},    {59'd0, bus.rd_o}, 64'd0);
    check({tag, "_data"},  {32'd0, bus.reg_data_o}, 64'd0);
    check({tag, "_err"},   {63'd0, bus.load_err_o}, 64'd0);
    check({tag, "_cnt"},   {32'd0, bus.retire_cnt_o}, 64'd0);
    check({tag, "_ready"}, {63'd0, bus.ready_o}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int unsigned cnt_before;
    int p_dv;

    m_busy = 1'b0; m_wait = 0; m_cnt = 0;
    m_f3 = 0; m_off = 0; m_rd = 0;
    exp_rd = '0; exp_data = '0;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_state("rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // ALU back-to-back
    drive(1'b1, 6'b000000, 3'd0, 2'd0, 5'd3, 32'h11, 1'b0, 32'd0, 1'b0); step();
    check("alu1_rd", {59'd0, bus.rd_o}, 64'd3);
    check("alu1_data", {32'd0, bus.reg_data_o}, 64'h11);
    drive(1'b1, 6'b000000, 3'd0, 2'd0, 5'd4, 32'h22, 1'b0, 32'd0, 1'b0); step();
    check("alu2_we", {63'd0, bus.reg_we_o}, 64'd1);
    check("alu2_data", {32'd0, bus.reg_data_o}, 64'h22);
    check("alu2_cnt", {32'd0, bus.retire_cnt_o}, 64'd2);
    idle(); step();

    // store, then ALU to x0: no writes, both retire
    drive(1'b1, 6'b101000, 3'd0, 2'd0, 5'd7, 32'h55, 1'b0, 32'd0, 1'b0); step();
    drive(1'b1, 6'b000000, 3'd0, 2'd0, 5'd0, 32'h66, 1'b0, 32'd0, 1'b0); step();
    check("x0_we", {63'd0, bus.reg_we_o}, 64'd0);
    idle(); step();
    check("x0_cnt", {32'd0, bus.retire_cnt_o}, 64'd4);

    // delayed LB, byte lane 2
    drive(1'b1, 6'b100000, 3'b000, 2'd2, 5'd5, 32'd0, 1'b0, 32'd0, 1'b0); step();
    idle(); step(); step();
    drive(1'b0, 6'd0, 3'd0, 2'd0, 5'd0, 32'd0, 1'b1, 32'h12F45678, 1'b0); step();
    check("lb_rd", {59'd0, bus.rd_o}, 64'd5);
    check("lb_data", {32'd0, bus.reg_data_o}, 64'hFFFFFFF4);
    idle(); step();

    // same-cycle LHU, upper half
    drive(1'b1, 6'b100000, 3'b101, 2'd2, 5'd9, 32'd0, 1'b1, 32'h8001ABCD, 1'b0); step();
    check("lhu_data", {32'd0, bus.reg_data_o}, 64'h00008001);
    idle(); step();

    // timeout: error pulse 16 cycles after accept
    drive(1'b1, 6'b100000, 3'b010, 2'd0, 5'd6, 32'd0, 1'b0, 32'd0, 1'b0); step();
    idle();
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      step();
      if (bus.load_err_o) lat = i;
    end
    check("timeout_lat", 64'(lat), 64'd16);
    step();
    check("timeout_ready", {63'd0, bus.ready_o}, 64'd1);

    // flush wins over same-cycle data
    drive(1'b1, 6'b100000, 3'b010, 2'd0, 5'd8, 32'd0, 1'b0, 32'd0, 1'b0); step();
    cnt_before = m_cnt;
    drive(1'b0, 6'd0, 3'd0, 2'd0, 5'd0, 32'd0, 1'b1, 32'hCAFEF00D, 1'b1); step();
    check("flush_we", {63'd0, bus.reg_we_o}, 64'd0);
    check("flush_cnt", {32'd0, bus.retire_cnt_o}, {32'd0, cnt_before});
    idle(); step();

    // asynchronous reset in the middle of LOAD_WAIT
    drive(1'b1, 6'b100000, 3'b000, 2'd1, 5'd10, 32'd0, 1'b0, 32'd0, 1'b0); step();
    idle(); step();
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_state("midrst");
    m_busy = 1'b0; m_cnt = 0;
    #2;
    rst_n_i = 1'b1;

    // randomized traffic with varying memory latency
    p_dv = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom % 4)
          0: p_dv = 0;
          1: p_dv = 10;
          2: p_dv = 50;
          default: p_dv = 90;
        endcase
      end
      drive(($urandom % 4) != 0, 6'($urandom), 3'($urandom), 2'($urandom),
            (($urandom % 8) == 0) ? 5'd0 : 5'($urandom), $urandom,
            int'($urandom % 100) < p_dv, $urandom, ($urandom % 25) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
